// File: rtl/mul32_seq_ctrl.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per clock,
// start/busy/done handshake, 2*WIDTH-bit product register.
module mul32_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  done_q;
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   sum;

    // One shift-add step; the extra sum bit keeps the carry for the shift-in.
    always_comb begin
        pp  = mcand_q & {WIDTH{acc_q[0]}};
        sum = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, pp};
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d = a_i;
                    acc_d   = {{WIDTH{1'b0}}, b_i};
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl: latency, results, ignored starts,
// async reset abort and back-to-back throughput.
module tb_mul32_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] product_o;

    int n_cmp = 0;
    int n_err = 0;

    mul32_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .product_o (product_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Counts cycles after the accept edge until done, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dc;
        int dk;
        int d1;
        int d2;

        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_product", product_o, 64'd0);
        rst_n = 1'b1;

        // 3 * 5
        issue(32'd3, 32'd5);
        check("t1_busy_after_accept", 64'(busy_o), 64'd1);
        check("t1_done_after_accept", 64'(done_o), 64'd0);
        wait_done(lat);
        check("t1_latency", 64'(lat), 64'd32);
        check("t1_product", product_o, 64'h0000_0000_0000_000F);
        check("t1_busy_in_done", 64'(busy_o), 64'd1);
        @(negedge clk);
        check("t1_busy_low_after", 64'(busy_o), 64'd0);
        check("t1_done_low_after", 64'(done_o), 64'd0);

        // All-ones operands: carry through every step
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        check("t2_latency", 64'(lat), 64'd32);
        check("t2_product", product_o, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);

        // Multiply by one, then hold, then zero multiplicand
        issue(32'h0545_3FAF, 32'h0000_0001);
        wait_done(lat);
        check("t3a_product", product_o, 64'h0000_0000_0545_3FAF);
        repeat (3) @(negedge clk);
        check("t3_hold_product", product_o, 64'h0000_0000_0545_3FAF);
        issue(32'h0000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check("t3b_latency", 64'(lat), 64'd32);
        check("t3b_product", product_o, 64'd0);
        @(negedge clk);

        // Extra starts in CALC cycle 10 and in DONE are ignored
        issue(32'd7, 32'd9);
        dc = 0;
        dk = -1;
        for (int k = 0; k < 40; k++) begin
            if (done_o) begin
                dc++;
                dk = k;
            end
            start_i = (k == 10) || done_o;
            a_i     = 32'd2;
            b_i     = 32'd2;
            @(negedge clk);
        end
        start_i = 1'b0;
        check("t4_done_count", 64'(dc), 64'd1);
        check("t4_done_cycle", 64'(dk), 64'd32);
        check("t4_product", product_o, 64'h3F);
        check("t4_idle_after", 64'(busy_o), 64'd0);

        // Asynchronous reset mid-operation
        issue(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (16) @(negedge clk);
        check("t5_busy_before_rst", 64'(busy_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy_o), 64'd0);
        check("t5_rst_done", 64'(done_o), 64'd0);
        check("t5_rst_product", product_o, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_done_after_abort", 64'(done_o), 64'd0);
        check("t5_idle_after_abort", 64'(busy_o), 64'd0);
        issue(32'd6, 32'd7);
        wait_done(lat);
        check("t5_latency", 64'(lat), 64'd32);
        check("t5_product", product_o, 64'h2A);
        @(negedge clk);

        // start held high for 100 cycles: one result every 34 cycles
        start_i = 1'b1;
        a_i     = 32'd2;
        b_i     = 32'd3;
        dc = 0;
        d1 = -1;
        d2 = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done_o) begin
                dc++;
                if (dc == 1) d1 = i;
                if (dc == 2) d2 = i;
                check("t6_product", product_o, 64'd6);
            end
        end
        start_i = 1'b0;
        check("t6_done_count", 64'(dc), 64'd2);
        check("t6_first_done", 64'(d1), 64'd33);
        check("t6_second_done", 64'(d2), 64'd67);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
